// File: rtl/ft600_proto_pkg.sv
// Protocol constants and FSM encodings for the FT600 register bridge.
// Shared between the FPGA parser and the host-side test model.
package ft600_proto_pkg;

  // Frame markers
  localparam logic [7:0] SYNC_CMD    = 8'hA5;
  localparam logic [7:0] SYNC_RSP    = 8'h5A;

  // Command opcodes (also echoed as response codes on success)
  localparam logic [7:0] OP_WRITE    = 8'h01;
  localparam logic [7:0] OP_READ     = 8'h02;

  // Error response codes
  localparam logic [7:0] RSP_TIMEOUT = 8'hEE;
  localparam logic [7:0] RSP_BADOP   = 8'hFF;

  typedef enum logic [2:0] {
    ST_HUNT     = 3'd0,
    ST_DECODE   = 3'd1,
    ST_GET_ADDR = 3'd2,
    ST_GET_DATA = 3'd3,
    ST_WR_EXEC  = 3'd4,
    ST_RD_WAIT  = 3'd5,
    ST_RESP0    = 3'd6,
    ST_RESP1    = 3'd7
  } state_t;

  // First response word: sync marker followed by the status/op code.
  function automatic logic [15:0] rsp_word(input logic [7:0] code);
    return {SYNC_RSP, code};
  endfunction

endpackage

// File: rtl/ft600_word_fetch.sv
// RX FIFO pop handshake: one rx_en pulse per word, data presented one cycle
// later together with a single-cycle word_valid.
module ft600_word_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        rx_empty,
  input  logic [15:0] rx_data,
  output logic        rx_en,
  output logic [15:0] word,
  output logic        word_valid
);

  logic arm_q, arm_d;
  logic pend_q, pend_d;

  // Pop only when data exists and no pop is outstanding; arm_q keeps rx_en
  // low while reset is asserted and for the first edge after release.
  always_comb begin
    rx_en      = arm_q & fetch_en & ~rx_empty & ~pend_q;
    arm_d      = 1'b1;
    pend_d     = rx_en;
    word       = rx_data;
    word_valid = pend_q;
  end

  // Handshake state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arm_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      arm_q  <= arm_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/ft600_reg_bridge.sv
// Command parser between the FT600 bridge FIFOs and a simple register bus.
//
//   state       | meaning
//   ------------+------------------------------------------------------
//   ST_HUNT     | pop words until one carries the A5 sync byte
//   ST_DECODE   | classify the opcode latched from the header
//   ST_GET_ADDR | pop address word; READ issues reg_re on leaving
//   ST_GET_DATA | pop write-data word
//   ST_WR_EXEC  | reg_we high for this single cycle
//   ST_RD_WAIT  | wait for reg_rvalid, bounded by the timeout counter
//   ST_RESP0    | push {5A, code}; held while tx_full
//   ST_RESP1    | push read data (successful READ only); held while tx_full
module ft600_reg_bridge
  import ft600_proto_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255,
  parameter int ERR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rx_en,
  input  logic [15:0]       rx_data,
  input  logic              rx_empty,
  output logic              tx_en,
  output logic [15:0]       tx_data,
  input  logic              tx_full,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [15:0]       reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [15:0]       reg_rdata,
  input  logic              reg_rvalid,
  output logic [ERR_W-1:0]  err_count
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT);

  state_t            state_q, state_d;
  logic [7:0]        op_q, op_d;
  logic [7:0]        code_q, code_d;
  logic              rd_ok_q, rd_ok_d;
  logic [15:0]       rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              err_inc;

  logic              fetch_en;
  logic [15:0]       word;
  logic              word_valid;

  ft600_word_fetch u_fetch (
    .clk        (clk),
    .rst        (rst),
    .fetch_en   (fetch_en),
    .rx_empty   (rx_empty),
    .rx_data    (rx_data),
    .rx_en      (rx_en),
    .word       (word),
    .word_valid (word_valid)
  );

  // Words are requested only in the states that consume them; a pop is never
  // left outstanding on exit because each of these states leaves on word_valid.
  always_comb begin
    fetch_en = (state_q == ST_HUNT) || (state_q == ST_GET_ADDR) ||
               (state_q == ST_GET_DATA);
  end

  // Next-state, strobe and datapath decode
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    code_d  = code_q;
    rd_ok_d = rd_ok_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    err_inc = 1'b0;

    case (state_q)
      ST_HUNT: begin
        if (word_valid) begin
          if (word[15:8] == SYNC_CMD) begin
            op_d    = word[7:0];
            state_d = ST_DECODE;
          end else begin
            err_inc = 1'b1;
          end
        end
      end

      ST_DECODE: begin
        if ((op_q == OP_WRITE) || (op_q == OP_READ)) begin
          state_d = ST_GET_ADDR;
        end else begin
          code_d  = RSP_BADOP;
          rd_ok_d = 1'b0;
          err_inc = 1'b1;
          state_d = ST_RESP0;
        end
      end

      ST_GET_ADDR: begin
        if (word_valid) begin
          addr_d = word[ADDR_W-1:0];
          if (op_q == OP_READ) begin
            re_d    = 1'b1;
            cnt_d   = TMO_LOAD;
            state_d = ST_RD_WAIT;
          end else begin
            state_d = ST_GET_DATA;
          end
        end
      end

      ST_GET_DATA: begin
        if (word_valid) begin
          wdata_d = word;
          we_d    = 1'b1;
          state_d = ST_WR_EXEC;
        end
      end

      ST_WR_EXEC: begin
        code_d  = OP_WRITE;
        rd_ok_d = 1'b0;
        state_d = ST_RESP0;
      end

      // Down-counter starts at TIMEOUT in the reg_re cycle; reaching zero
      // without rvalid means TIMEOUT cycles have elapsed since the strobe.
      ST_RD_WAIT: begin
        if (reg_rvalid) begin
          rdata_d = reg_rdata;
          code_d  = OP_READ;
          rd_ok_d = 1'b1;
          state_d = ST_RESP0;
        end else if (cnt_q == '0) begin
          code_d  = RSP_TIMEOUT;
          rd_ok_d = 1'b0;
          err_inc = 1'b1;
          state_d = ST_RESP0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_RESP0: begin
        if (!tx_full) begin
          state_d = rd_ok_q ? ST_RESP1 : ST_HUNT;
        end
      end

      ST_RESP1: begin
        if (!tx_full) begin
          state_d = ST_HUNT;
        end
      end

      default: state_d = ST_HUNT;
    endcase

    err_d = err_q;
    if (err_inc && (err_q != '1)) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  // Response push: tx_en follows tx_full in the same cycle so a full FIFO
  // simply stalls the FSM with the word held on tx_data.
  always_comb begin
    tx_en   = ((state_q == ST_RESP0) || (state_q == ST_RESP1)) && !tx_full;
    tx_data = '0;
    if (state_q == ST_RESP0) begin
      tx_data = rsp_word(code_q);
    end else if (state_q == ST_RESP1) begin
      tx_data = rdata_q;
    end
  end

  // Output and state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_HUNT;
      op_q    <= '0;
      code_q  <= '0;
      rd_ok_q <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      code_q  <= code_d;
      rd_ok_q <= rd_ok_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
    end
  end

  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_ft600_reg_bridge.sv
// Directed bench for ft600_reg_bridge: FIFO and register-slave models plus
// a table of frames with hand-computed responses.
module tb_ft600_reg_bridge;

  logic        clk;
  logic        rst;
  logic        rx_en;
  logic [15:0] rx_data;
  logic        rx_empty;
  logic        tx_en;
  logic [15:0] tx_data;
  logic        tx_full;
  logic [15:0] reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [15:0] reg_rdata;
  logic        reg_rvalid;
  logic [7:0]  err_count;

  ft600_reg_bridge #(.ADDR_W(16), .TIMEOUT(255), .ERR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_en      (rx_en),
    .rx_data    (rx_data),
    .rx_empty   (rx_empty),
    .tx_en      (tx_en),
    .tx_data    (tx_data),
    .tx_full    (tx_full),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_we     (reg_we),
    .reg_re     (reg_re),
    .reg_rdata  (reg_rdata),
    .reg_rvalid (reg_rvalid),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int viol    = 0;
  int cyc     = 0;
  int we_cnt  = 0;
  int re_cnt  = 0;
  int we_cyc  = 0;
  int re_cyc  = 0;
  int tx0_cyc = 0;
  int rv_dly  = 0;
  int rv_cnt  = 0;
  logic [15:0] rv_data = 16'h0;
  bit rx_pop_s = 1'b0;
  logic [15:0] rxq[$];
  logic [15:0] txq[$];

  typedef struct {
    int          nw;
    logic [15:0] w0, w1, w2;
    int          rv_dly;
    logic [15:0] rv_data;
    int          exp_we;
    int          exp_re;
    logic [15:0] exp_addr;
    logic [15:0] exp_wdata;
    int          exp_ntx;
    logic [15:0] exp_tx0, exp_tx1;
    int          exp_err;
    int          lat_kind;   // 0 none, 1 write push latency, 2 read timeout latency
    string       name;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_rx_drain(input int budget);
    int k = 0;
    while (rxq.size() != 0 && k < budget) begin
      tick(1);
      k++;
    end
    check("rx_drain", rxq.size(), 0);
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k = 0;
    while (txq.size() < n && k < budget) begin
      tick(1);
      k++;
    end
  endtask

  task automatic wait_re(input int re0, input int budget);
    int k = 0;
    while (re_cnt == re0 && k < budget) begin
      tick(1);
      k++;
    end
  endtask

  function automatic logic [31:0] txq_at(input int idx);
    if (txq.size() > idx) return {16'h0, txq[idx]};
    return 32'hFFFF_FFFF;
  endfunction

  // Monitor: samples DUT outputs on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      rx_pop_s = rx_en;
      if (rx_en && rx_empty) begin
        viol++;
        $display("FAIL rx_en_while_empty actual=1 required=0 cycle=%0d", cyc);
      end
      if (tx_en) begin
        if (tx_full) begin
          viol++;
          $display("FAIL tx_en_while_full actual=1 required=0 cycle=%0d", cyc);
        end
        if (txq.size() == 0) tx0_cyc = cyc;
        txq.push_back(tx_data);
      end
      if (reg_we) begin
        we_cnt++;
        we_cyc = cyc;
      end
      if (reg_re) begin
        re_cnt++;
        re_cyc = cyc;
      end
      if (reg_we && reg_re) begin
        viol++;
        $display("FAIL we_re_overlap actual=1 required=0 cycle=%0d", cyc);
      end
    end
  end

  // RX FIFO and register-slave models, driven just after the rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rx_pop_s && rxq.size() != 0) rx_data = rxq.pop_front();
      rx_pop_s = 1'b0;
      rx_empty = (rxq.size() == 0);
      reg_rvalid = 1'b0;
      if (reg_re) begin
        rv_cnt = (rv_dly > 0) ? rv_dly : 0;
      end else if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          reg_rvalid = 1'b1;
          reg_rdata  = rv_data;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int we0, re0;

    // err expectations accumulate across the table (no reset between rows)
    vecs[0] = '{3, 16'hA501, 16'h0010, 16'hBEEF, 0, 16'h0, 1, 0, 16'h0010, 16'hBEEF, 1, 16'h5A01, 16'h0, 0, 1, "wr_basic"};
    vecs[1] = '{2, 16'hA502, 16'h0020, 16'h0, 3, 16'h1234, 0, 1, 16'h0020, 16'hBEEF, 2, 16'h5A02, 16'h1234, 0, 0, "rd_basic"};
    vecs[2] = '{2, 16'hA502, 16'h0030, 16'h0, -1, 16'h0, 0, 1, 16'h0030, 16'hBEEF, 1, 16'h5AEE, 16'h0, 1, 2, "rd_timeout"};
    vecs[3] = '{3, 16'hA501, 16'h0040, 16'hCAFE, 0, 16'h0, 1, 0, 16'h0040, 16'hCAFE, 1, 16'h5A01, 16'h0, 1, 1, "wr_after_to"};
    vecs[4] = '{2, 16'h0000, 16'h1234, 16'h0, 0, 16'h0, 0, 0, 16'h0040, 16'hCAFE, 0, 16'h0, 16'h0, 3, 0, "garbage"};
    vecs[5] = '{3, 16'hA501, 16'h0050, 16'h1111, 0, 16'h0, 1, 0, 16'h0050, 16'h1111, 1, 16'h5A01, 16'h0, 3, 1, "wr_after_garbage"};
    vecs[6] = '{1, 16'hA577, 16'h0, 16'h0, 0, 16'h0, 0, 0, 16'h0050, 16'h1111, 1, 16'h5AFF, 16'h0, 4, 0, "bad_op"};
    vecs[7] = '{2, 16'hA502, 16'h1234, 16'h0, 1, 16'hA5A5, 0, 1, 16'h1234, 16'h1111, 2, 16'h5A02, 16'hA5A5, 4, 0, "rd_fast"};

    rst        = 1'b0;
    tx_full    = 1'b0;
    rx_empty   = 1'b1;
    rx_data    = 16'h0;
    reg_rdata  = 16'h0;
    reg_rvalid = 1'b0;

    tick(3);
    check("rst_rx_en", rx_en, 0);
    check("rst_tx_en", tx_en, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_reg_we", reg_we, 0);
    check("rst_reg_re", reg_re, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_err", err_count, 0);
    rst = 1'b1;
    tick(2);

    for (int i = 0; i < 8; i++) begin
      we0 = we_cnt;
      re0 = re_cnt;
      txq.delete();
      rv_dly  = vecs[i].rv_dly;
      rv_data = vecs[i].rv_data;
      rxq.push_back(vecs[i].w0);
      if (vecs[i].nw > 1) rxq.push_back(vecs[i].w1);
      if (vecs[i].nw > 2) rxq.push_back(vecs[i].w2);
      wait_rx_drain(100);
      wait_tx(vecs[i].exp_ntx, 600);
      tick(6);
      check({vecs[i].name, "_ntx"}, txq.size(), vecs[i].exp_ntx);
      if (vecs[i].exp_ntx > 0) check({vecs[i].name, "_tx0"}, txq_at(0), {16'h0, vecs[i].exp_tx0});
      if (vecs[i].exp_ntx > 1) check({vecs[i].name, "_tx1"}, txq_at(1), {16'h0, vecs[i].exp_tx1});
      check({vecs[i].name, "_we"}, we_cnt - we0, vecs[i].exp_we);
      check({vecs[i].name, "_re"}, re_cnt - re0, vecs[i].exp_re);
      check({vecs[i].name, "_addr"}, reg_addr, vecs[i].exp_addr);
      check({vecs[i].name, "_wdata"}, reg_wdata, vecs[i].exp_wdata);
      check({vecs[i].name, "_err"}, err_count, vecs[i].exp_err);
      if (vecs[i].lat_kind == 1) check({vecs[i].name, "_push_lat"}, tx0_cyc - we_cyc, 1);
      if (vecs[i].lat_kind == 2) check({vecs[i].name, "_tmo_lat"}, tx0_cyc - re_cyc, 256);
    end

    // Response held while the TX FIFO is full
    txq.delete();
    tx_full = 1'b1;
    rv_dly  = 2;
    rv_data = 16'h5678;
    re0 = re_cnt;
    rxq.push_back(16'hA502);
    rxq.push_back(16'h0080);
    wait_re(re0, 100);
    check("hold_re", re_cnt - re0, 1);
    tick(20);
    check("hold_no_tx", txq.size(), 0);
    check("hold_word", tx_data, 16'h5A02);
    tx_full = 1'b0;
    wait_tx(2, 50);
    tick(4);
    check("hold_ntx", txq.size(), 2);
    check("hold_tx0", txq_at(0), 32'h5A02);
    check("hold_tx1", txq_at(1), 32'h5678);

    // Reset in the middle of a WRITE frame
    txq.delete();
    we0 = we_cnt;
    rxq.push_back(16'hA501);
    rxq.push_back(16'h0060);
    wait_rx_drain(50);
    tick(3);
    rst = 1'b0;
    tick(2);
    check("midrst_err", err_count, 0);
    check("midrst_addr", reg_addr, 0);
    rst = 1'b1;
    tick(5);
    check("midrst_no_we", we_cnt - we0, 0);
    check("midrst_no_tx", txq.size(), 0);
    rv_dly  = 2;
    rv_data = 16'h9ABC;
    rxq.push_back(16'hA502);
    rxq.push_back(16'h0070);
    wait_rx_drain(50);
    wait_tx(2, 100);
    tick(4);
    check("post_rst_ntx", txq.size(), 2);
    check("post_rst_tx0", txq_at(0), 32'h5A02);
    check("post_rst_tx1", txq_at(1), 32'h9ABC);
    check("post_rst_addr", reg_addr, 16'h0070);
    check("post_rst_we", we_cnt - we0, 0);

    // Error counter saturation
    for (int i = 0; i < 255; i++) rxq.push_back(16'h0000);
    wait_rx_drain(2000);
    tick(4);
    check("err_at_255", err_count, 8'hFF);
    for (int i = 0; i < 5; i++) rxq.push_back(16'h1200);
    wait_rx_drain(100);
    tick(4);
    check("err_saturated", err_count, 8'hFF);

    check("protocol_violations", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
